// File: rtl/reverb_mac.sv
// ---------------------------------------------------------------------------
// reverb_mac
// Convolution-reverb multiply/accumulate stage. It consumes the memory read
// stream as alternating (coefficient, delayed-sample) word pairs, one pair
// per tap. It accumulates every tap of one ADC frame into a saturating
// accumulator, applies the Q8.8 output gain, and presents one saturated
// 16-bit wet sample per frame.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   frame_start  one-cycle pulse that opens a frame and clears the accumulator
//   num_taps     taps in this frame, captured on frame_start
//   gain         unsigned Q8.8 output gain, captured on frame_start
//   word_valid   word_data carries a word this cycle
//   word_data    coefficient or sample word from the memory read path
//   word_ready   word accepted when word_valid && word_ready
//   out_valid    one-cycle pulse, out_sample updated
//   out_sample   signed wet sample, held until the next out_valid
//   busy         frame in progress
//   sat_flag     sticky: an accumulator or output clip occurred since reset
//   overrun_flag sticky: frame_start arrived while a frame was in progress
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for frame_start, words ignored
// COEF  | waiting for the coefficient word of the current tap
// SAMP  | waiting for the delayed-sample word, product registered
// ACCUM | product added into the saturating accumulator, tap counted
// SCALE | accumulator scaled to 16 bits, gain applied, result registered
// OUT   | out_valid pulse for the registered result
// ---------------------------------------------------------------------------
module reverb_mac #(
   parameter int TAP_W = 11,
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic [TAP_W-1:0] num_taps,
   input  logic [15:0]      gain,
   input  logic             word_valid,
   input  logic [15:0]      word_data,
   output logic             word_ready,
   output logic             out_valid,
   output logic [15:0]      out_sample,
   output logic             busy,
   output logic             sat_flag,
   output logic             overrun_flag
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COEF  = 3'd1,
      S_SAMP  = 3'd2,
      S_ACCUM = 3'd3,
      S_SCALE = 3'd4,
      S_OUT   = 3'd5
   } state_t;

   state_t                   r_state;
   logic [TAP_W-1:0]         r_num_taps;
   logic [TAP_W-1:0]         r_tap_cnt;
   logic [15:0]              r_gain;
   logic                     r_neg;
   logic [7:0]               r_mag;
   logic signed [23:0]       r_prod;
   logic signed [ACC_W-1:0]  r_acc;
   logic [15:0]              r_out_sample;
   logic                     r_out_valid;
   logic                     r_sat;
   logic                     r_overrun;

   // Tap product: a signed 16-bit sample times an unsigned 8-bit magnitude
   // always fits in 24 signed bits, including the negated extreme
   // (32768 * 255 < 2^23), so no clipping is needed here.
   logic signed [23:0]       w_samp_x;
   logic signed [23:0]       w_mag_x;
   logic signed [23:0]       w_prod_mag;
   logic signed [23:0]       w_prod;

   assign w_samp_x   = {{8{word_data[15]}}, word_data};
   assign w_mag_x    = {16'd0, r_mag};
   assign w_prod_mag = w_samp_x * w_mag_x;
   assign w_prod     = r_neg ? -w_prod_mag : w_prod_mag;

   // Accumulate one bit wider so overflow shows up as disagreeing top bits.
   logic signed [ACC_W:0]    w_acc_sum;
   logic                     w_acc_ovf;
   logic signed [ACC_W-1:0]  w_acc_sat;

   assign w_acc_sum = {r_acc[ACC_W-1], r_acc} + {{(ACC_W-23){r_prod[23]}}, r_prod};
   assign w_acc_ovf = w_acc_sum[ACC_W] ^ w_acc_sum[ACC_W-1];
   assign w_acc_sat = !w_acc_ovf     ? w_acc_sum[ACC_W-1:0] :
                      w_acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                         {1'b0, {(ACC_W-1){1'b1}}};

   // Drop the Q0.8 coefficient fraction, then clip to 16 bits. The value
   // fits only when every bit from 15 upward equals the sign.
   logic signed [ACC_W-1:0]  w_acc_sh;
   logic                     w_t_ovf;
   logic signed [15:0]       w_t;

   assign w_acc_sh = r_acc >>> 8;
   assign w_t_ovf  = ~((&w_acc_sh[ACC_W-1:15]) | ~(|w_acc_sh[ACC_W-1:15]));
   assign w_t      = !w_t_ovf             ? w_acc_sh[15:0] :
                     w_acc_sh[ACC_W-1]    ? 16'sh8000 : 16'sh7FFF;

   // Gain stage: signed 16 x unsigned 16 needs 33 signed bits; the Q8.8
   // fraction is removed afterwards and the result clipped again.
   logic signed [32:0]       w_t_x;
   logic signed [32:0]       w_gain_x;
   logic signed [32:0]       w_y_full;
   logic signed [32:0]       w_y_sh;
   logic                     w_y_ovf;
   logic [15:0]              w_y;

   assign w_t_x    = {{17{w_t[15]}}, w_t};
   assign w_gain_x = {17'd0, r_gain};
   assign w_y_full = w_t_x * w_gain_x;
   assign w_y_sh   = w_y_full >>> 8;
   assign w_y_ovf  = ~((&w_y_sh[32:15]) | ~(|w_y_sh[32:15]));
   assign w_y      = !w_y_ovf    ? w_y_sh[15:0] :
                     w_y_sh[32]  ? 16'h8000 : 16'h7FFF;

   logic [TAP_W-1:0]         w_tap_next;
   assign w_tap_next = r_tap_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_num_taps   <= '0;
         r_tap_cnt    <= '0;
         r_gain       <= '0;
         r_neg        <= 1'b0;
         r_mag        <= '0;
         r_prod       <= '0;
         r_acc        <= '0;
         r_out_sample <= '0;
         r_out_valid  <= 1'b0;
         r_sat        <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (frame_start) begin
            // A new frame always wins: any frame in flight is dropped and any
            // word handshaking this cycle is discarded.
            if (r_state != S_IDLE) begin
               r_overrun <= 1'b1;
            end
            r_num_taps <= num_taps;
            r_gain     <= gain;
            r_acc      <= '0;
            r_tap_cnt  <= '0;
            r_state    <= (num_taps == '0) ? S_SCALE : S_COEF;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_IDLE;
               end
               S_COEF: begin
                  if (word_valid) begin
                     // Bits [15:9] carry offset fields for the memory side.
                     r_neg   <= word_data[8];
                     r_mag   <= word_data[7:0];
                     r_state <= S_SAMP;
                  end
               end
               S_SAMP: begin
                  if (word_valid) begin
                     r_prod  <= w_prod;
                     r_state <= S_ACCUM;
                  end
               end
               S_ACCUM: begin
                  r_acc     <= w_acc_sat;
                  r_tap_cnt <= w_tap_next;
                  if (w_acc_ovf) begin
                     r_sat <= 1'b1;
                  end
                  r_state <= (w_tap_next == r_num_taps) ? S_SCALE : S_COEF;
               end
               S_SCALE: begin
                  r_out_sample <= w_y;
                  r_out_valid  <= 1'b1;
                  if (w_t_ovf || w_y_ovf) begin
                     r_sat <= 1'b1;
                  end
                  r_state <= S_OUT;
               end
               S_OUT: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign word_ready   = (r_state == S_COEF) || (r_state == S_SAMP);
   assign busy         = (r_state != S_IDLE);
   assign out_valid    = r_out_valid;
   assign out_sample   = r_out_sample;
   assign sat_flag     = r_sat;
   assign overrun_flag = r_overrun;

endmodule

// File: tb/tb_reverb_mac.sv
module tb_reverb_mac;
   localparam int TAP_W = 11;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             frame_start;
   logic [TAP_W-1:0] num_taps;
   logic [15:0]      gain;
   logic             word_valid;
   logic [15:0]      word_data;
   logic             word_ready;
   logic             out_valid;
   logic [15:0]      out_sample;
   logic             busy;
   logic             sat_flag;
   logic             overrun_flag;

   always #5 clk = ~clk;

   reverb_mac #(.TAP_W(TAP_W), .ACC_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_start  (frame_start),
      .num_taps     (num_taps),
      .gain         (gain),
      .word_valid   (word_valid),
      .word_data    (word_data),
      .word_ready   (word_ready),
      .out_valid    (out_valid),
      .out_sample   (out_sample),
      .busy         (busy),
      .sat_flag     (sat_flag),
      .overrun_flag (overrun_flag)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int ov_cnt  = 0;

   // Counts cycles in which out_valid was high.
   always @(posedge clk) if (out_valid) ov_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          nt;
      logic [15:0] g;
      logic [15:0] c0, s0;   // tap 0
      logic [15:0] c1, s1;   // taps 1 and up
      logic [15:0] ex;
      logic        sat;      // expected sticky sat_flag after this frame
      int          stall;    // idle cycles between coefficient and sample
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input int nt, input logic [15:0] g,
                               input logic [15:0] c0, input logic [15:0] s0,
                               input logic [15:0] c1, input logic [15:0] s1,
                               input logic [15:0] ex, input logic sat,
                               input int stall);
      vec_t v;
      v.nt = nt; v.g = g; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1;
      v.ex = ex; v.sat = sat; v.stall = stall;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Entered and left at a negedge.
   task automatic feed_word(input logic [15:0] d);
      bit ok = 0;
      word_valid = 1'b1;
      word_data  = d;
      for (int n = 0; n < 50; n++) begin
         if (word_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (ok) begin
         @(posedge clk);
         @(negedge clk);
      end
      word_valid = 1'b0;
      if (!ok) begin
         n_tests++; n_fail++;
         $display("FAIL handshake timeout: word 0x%0h not accepted, required acceptance", d);
      end
   endtask

   task automatic feed_tap(input logic [15:0] c, input logic [15:0] s, input int stall);
      feed_word(c);
      repeat (stall) @(negedge clk);
      feed_word(s);
   endtask

   task automatic start_frame(input logic [TAP_W-1:0] nt, input logic [15:0] g);
      frame_start = 1'b1;
      num_taps    = nt;
      gain        = g;
      @(posedge clk);
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   // Cycle 1 is the negedge on entry; returns the cycle in which out_valid shows.
   task automatic wait_out(output int cnt);
      cnt = 1;
      while (!out_valid && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      if (!out_valid) begin
         n_tests++; n_fail++;
         $display("FAIL out_valid timeout: no pulse within %0d cycles, required one", cnt);
         cnt = -1;
      end
   endtask

   initial begin
      int cnt;
      int ov0;
      vec_t v;

      rst_n = 1'b0; frame_start = 1'b0; num_taps = '0; gain = '0;
      word_valid = 1'b0; word_data = '0;

      vq.push_back(mk(1, 16'h0100, 16'h0080, 16'h1000, 16'h0000, 16'h0000, 16'h0800, 1'b0, 0));
      vq.push_back(mk(2, 16'h0200, 16'h0180, 16'h1000, 16'h0040, 16'h2000, 16'h0000, 1'b0, 0));
      vq.push_back(mk(2, 16'h0200, 16'h0180, 16'h1000, 16'h0100, 16'h2000, 16'hF000, 1'b0, 0));
      vq.push_back(mk(1, 16'h0100, 16'h0080, 16'h1000, 16'h0000, 16'h0000, 16'h0800, 1'b0, 5));
      vq.push_back(mk(1, 16'h0100, 16'hFE80, 16'h1000, 16'h0000, 16'h0000, 16'h0800, 1'b0, 0));
      vq.push_back(mk(1, 16'h0180, 16'h0040, 16'hF000, 16'h0000, 16'h0000, 16'hFA00, 1'b0, 0));
      vq.push_back(mk(4, 16'h0100, 16'h00FF, 16'h7FFF, 16'h00FF, 16'h7FFF, 16'h7FFF, 1'b1, 0));
      vq.push_back(mk(4, 16'h0100, 16'h00FF, 16'h8000, 16'h00FF, 16'h8000, 16'h8000, 1'b1, 2));
      vq.push_back(mk(1, 16'h2000, 16'h0080, 16'h1000, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 0));

      repeat (3) @(negedge clk);
      chk("reset busy",         busy,         0);
      chk("reset word_ready",   word_ready,   0);
      chk("reset out_valid",    out_valid,    0);
      chk("reset out_sample",   out_sample,   0);
      chk("reset sat_flag",     sat_flag,     0);
      chk("reset overrun_flag", overrun_flag, 0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         start_frame(TAP_W'(v.nt), v.g);
         for (int t = 0; t < v.nt; t++) begin
            if (t == 0) feed_tap(v.c0, v.s0, v.stall);
            else        feed_tap(v.c1, v.s1, v.stall);
         end
         wait_out(cnt);
         chk($sformatf("v%0d out_sample", i), out_sample, v.ex);
         chk($sformatf("v%0d latency", i), cnt, 3);
         chk($sformatf("v%0d sat_flag", i), sat_flag, v.sat);
         chk($sformatf("v%0d overrun_flag", i), overrun_flag, 0);
         @(negedge clk);
         chk($sformatf("v%0d out_valid width", i), out_valid, 0);
         chk($sformatf("v%0d busy after", i), busy, 0);
      end

      // Zero taps: result 0, pulse two cycles after frame_start.
      start_frame('0, 16'h0100);
      wait_out(cnt);
      chk("zero taps latency", cnt, 2);
      chk("zero taps out_sample", out_sample, 16'h0000);
      @(negedge clk);

      // Backpressure in ACCUM, then a long frame that clips the accumulator.
      start_frame(TAP_W'(260), 16'h0100);
      feed_word(16'h00FF);
      feed_word(16'h7FFF);
      chk("accum word_ready", word_ready, 0);
      chk("accum busy", busy, 1);
      for (int t = 1; t < 260; t++) feed_tap(16'h00FF, 16'h7FFF, 0);
      wait_out(cnt);
      chk("acc clip out_sample", out_sample, 16'h7FFF);
      chk("acc clip latency", cnt, 3);
      @(negedge clk);

      // Overrun: restart during SAMP with a word offered in the same cycle.
      start_frame(TAP_W'(3), 16'h0100);
      ov0 = ov_cnt;
      feed_tap(16'h0080, 16'h1000, 0);
      feed_word(16'h0080);
      word_valid  = 1'b1;
      word_data   = 16'h7FFF;
      frame_start = 1'b1;
      num_taps    = TAP_W'(1);
      gain        = 16'h0100;
      @(posedge clk);
      @(negedge clk);
      frame_start = 1'b0;
      word_valid  = 1'b0;
      chk("overrun_flag set", overrun_flag, 1);
      feed_tap(16'h0040, 16'h1000, 0);
      wait_out(cnt);
      chk("overrun new frame out_sample", out_sample, 16'h0400);
      chk("overrun new frame latency", cnt, 3);
      @(negedge clk);
      chk("overrun pulse count", ov_cnt - ov0, 1);

      // Reset during SAMP.
      start_frame(TAP_W'(1), 16'h0100);
      feed_word(16'h0080);
      ov0 = ov_cnt;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midreset busy",         busy,         0);
      chk("midreset out_sample",   out_sample,   0);
      chk("midreset sat_flag",     sat_flag,     0);
      chk("midreset overrun_flag", overrun_flag, 0);
      chk("midreset out_valid",    out_valid,    0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("midreset no pulse", ov_cnt - ov0, 0);
      start_frame(TAP_W'(1), 16'h0100);
      feed_tap(16'h0080, 16'h1000, 0);
      wait_out(cnt);
      chk("post reset out_sample", out_sample, 16'h0800);
      chk("post reset latency", cnt, 3);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
